recon_frame_writer: RTL

- Collects reconstructed BLK_DIM x BLK_DIM pixel blocks from the reconstruction datapath and tiles them, in raster block order, into an internal IMG_W x IMG_H frame buffer.
- Uses a valid/ready handshake, writes one block row per cycle, and flags frame completion.
- Exposes a registered read port for downstream display/compare logic.
- Successor to the fixed 64-pixel single-block capture stage; generalised in pixel width, block size and image size.

---
 rtl/recon_frame_writer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/recon_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : recon_frame_writer
// Purpose  : Tiles reconstructed BLK_DIM x BLK_DIM blocks into a raster frame
//            buffer one block row per cycle; registered read port.
// Options  : define RECON_CHECKSUM_EN to add the frame_sum checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module recon_frame_writer #(
  parameter int PIX_W   = 8,
  parameter int BLK_DIM = 8,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               frame_restart,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [PIX_W*BLK_DIM*BLK_DIM-1:0]                   blk_pixels,
  output logic [$clog2((IMG_W/BLK_DIM)*(IMG_H/BLK_DIM))-1:0] blk_idx,
  output logic                                               frame_done,
  output logic                                               frame_valid,
  input  logic                                               rd_en,
  input  logic [$clog2(IMG_W*IMG_H)-1:0]                     rd_addr,
  output logic [PIX_W-1:0]                                   rd_data
`ifdef RECON_CHECKSUM_EN
  ,
  output logic [31:0]                                        frame_sum
`endif
);
  localparam int NBX      = IMG_W / BLK_DIM;
  localparam int NBY      = IMG_H / BLK_DIM;
  localparam int NBLK     = NBX * NBY;
  localparam int BI_W     = $clog2(NBLK);
  localparam int AW       = $clog2(IMG_W * IMG_H);
  localparam int ROW_BITS = PIX_W * BLK_DIM;
  localparam int NWORDS   = (IMG_W * IMG_H) / BLK_DIM;
  localparam int WA_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int RW       = (BLK_DIM > 1) ? $clog2(BLK_DIM) : 1;
  localparam int BX_W     = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int BY_W     = (NBY > 1) ? $clog2(NBY) : 1;
  localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic [BI_W-1:0]           blk_idx_q, blk_idx_d;
  logic                      frame_done_q, frame_done_d;
  logic                      frame_valid_q, frame_valid_d;
  logic [PIX_W-1:0]          rd_data_q, rd_data_d;
  logic [RW-1:0]             row_q, row_d;
  logic [BX_W-1:0]           bx_q, bx_d;
  logic [BY_W-1:0]           by_q, by_d;
  logic [BLK_DIM*ROW_BITS-1:0] blk_q, blk_d;

  // Buffer is organised as one word per block row so a whole row lands in one write.
  logic [ROW_BITS-1:0] frame_mem [NWORDS];
  logic                wr_en;
  logic [WA_W-1:0]     wr_word;
  logic [ROW_BITS-1:0] row_data;
  logic [WA_W-1:0]     rd_word;
  logic [RW-1:0]       rd_lane;
  logic [ROW_BITS-1:0] rd_row;

  assign row_data = blk_q[int'(row_q)*ROW_BITS +: ROW_BITS];
  assign wr_word  = WA_W'((int'(by_q)*BLK_DIM + int'(row_q))*NBX + int'(bx_q));
  assign rd_word  = WA_W'(rd_addr / AW'(BLK_DIM));
  assign rd_lane  = RW'(rd_addr % AW'(BLK_DIM));
  assign rd_row   = frame_mem[rd_word];

  assign in_ready    = in_ready_q;
  assign blk_idx     = blk_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_valid = frame_valid_q;
  assign rd_data     = rd_data_q;

`ifdef RECON_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, row_sum;
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < BLK_DIM; c++) begin
      row_sum = row_sum + 32'(row_data[c*PIX_W +: PIX_W]);
    end
  end
  assign frame_sum = sum_q;
`endif

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    blk_idx_d     = blk_idx_q;
    frame_done_d  = 1'b0;
    frame_valid_d = frame_valid_q;
    row_d         = row_q;
    bx_d          = bx_q;
    by_d          = by_q;
    blk_d         = blk_q;
    wr_en         = 1'b0;
`ifdef RECON_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = ({1'b0, rd_addr} < NPIX) ? rd_row[int'(rd_lane)*PIX_W +: PIX_W] : '0;
    end

    if (frame_restart) begin
      state_d       = S_IDLE;
      in_ready_d    = 1'b1;
      blk_idx_d     = '0;
      frame_valid_d = 1'b0;
      row_d         = '0;
      bx_d          = '0;
      by_d          = '0;
`ifdef RECON_CHECKSUM_EN
      sum_d         = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            blk_d      = blk_pixels;
            row_d      = '0;
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
            if (blk_idx_q == '0) begin
              frame_valid_d = 1'b0;
`ifdef RECON_CHECKSUM_EN
              sum_d         = '0;
`endif
            end
          end
        end
        S_WRITE: begin
          wr_en = 1'b1;
`ifdef RECON_CHECKSUM_EN
          sum_d = sum_q + row_sum;
`endif
          if (row_q == RW'(BLK_DIM-1)) begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
            row_d      = '0;
            if (blk_idx_q == BI_W'(NBLK-1)) begin
              frame_done_d  = 1'b1;
              frame_valid_d = 1'b1;
              blk_idx_d     = '0;
              bx_d          = '0;
              by_d          = '0;
            end else begin
              blk_idx_d = blk_idx_q + 1'b1;
              if (bx_q == BX_W'(NBX-1)) begin
                bx_d = '0;
                by_d = by_q + 1'b1;
              end else begin
                bx_d = bx_q + 1'b1;
              end
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      blk_idx_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_data_q     <= '0;
      row_q         <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      blk_q         <= '0;
`ifdef RECON_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      blk_idx_q     <= blk_idx_d;
      frame_done_q  <= frame_done_d;
      frame_valid_q <= frame_valid_d;
      rd_data_q     <= rd_data_d;
      row_q         <= row_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      blk_q         <= blk_d;
`ifdef RECON_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  // Frame contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_mem[wr_word] <= row_data;
    end
  end

endmodule
`default_nettype wire
